// File: rtl/rs232_arb_pkg.sv
// Shared definitions for the RS-232 transmit arbiter: state encoding,
// default end-of-message word and a constant clog2 helper.
package rs232_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    localparam logic [31:0] EOM_DEFAULT = 32'h0000_000A;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first request at or after ptr, wrapping.
module rr_pick
    import rs232_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic                    valid,
    output logic [clog2(N_REQ)-1:0] winner
);

    localparam int PW = clog2(N_REQ);

    logic [PW-1:0] idx;

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART tx stream between
// several stb/ack producers; a granted producer keeps the UART until EOM or idle timeout.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  ARB   | pick the next requester round-robin from ptr, latch its word
//  SEND  | present the latched word to the UART until it is acked
//  HOLD  | wait for the next word of the locked requester, or time out
module rs232_tx_arbiter
    import rs232_arb_pkg::*;
#(
    parameter int                 N_REQ   = 4,
    parameter int                 WIDTH   = 32,
    parameter logic [WIDTH-1:0]   EOM     = WIDTH'(EOM_DEFAULT),
    parameter int                 LOCK    = 1,
    parameter int                 TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ*WIDTH-1:0]   input_in,
    input  logic [N_REQ-1:0]         input_in_stb,
    output logic [N_REQ-1:0]         input_in_ack,
    output logic [WIDTH-1:0]         output_out,
    output logic                     output_out_stb,
    input  logic                     output_out_ack,
    output logic [clog2(N_REQ)-1:0]  grant_id,
    output logic                     timeout_stb
);

    localparam int PW = clog2(N_REQ);
    localparam int CW = clog2(TIMEOUT);

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gid_q, gid_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tstb_q, tstb_d;

    logic              pick_valid;
    logic [PW-1:0]     pick_w;
    logic [PW-1:0]     ptr_after_gid;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (input_in_stb),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_w)
    );

    assign ptr_after_gid = (gid_q == PW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            gid_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            cnt_q   <= '0;
            tstb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            tstb_q  <= tstb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        ack_d   = '0;
        cnt_d   = cnt_q;
        tstb_d  = 1'b0;
        case (state_q)
            ARB: begin
                if (pick_valid) begin
                    gid_d         = pick_w;
                    data_d        = input_in[pick_w*WIDTH +: WIDTH];
                    ack_d[pick_w] = 1'b1;
                    state_d       = SEND;
                end
            end
            SEND: begin
                if (output_out_ack) begin
                    if (LOCK == 0 || data_q == EOM) begin
                        ptr_d   = ptr_after_gid;
                        state_d = ARB;
                    end else begin
                        // Idle timer counts down; release fires on the edge it sits at zero.
                        cnt_d   = CW'(TIMEOUT - 1);
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (input_in_stb[gid_q]) begin
                    data_d        = input_in[gid_q*WIDTH +: WIDTH];
                    ack_d[gid_q]  = 1'b1;
                    state_d       = SEND;
                end else if (cnt_q == '0) begin
                    tstb_d  = 1'b1;
                    ptr_d   = ptr_after_gid;
                    state_d = ARB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign input_in_ack   = ack_q;
    assign output_out     = data_q;
    assign output_out_stb = (state_q == SEND);
    assign grant_id       = gid_q;
    assign timeout_stb    = tstb_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: a locked instance (TIMEOUT=16) and an unlocked one.
module tb_rs232_tx_arbiter;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    // locked instance
    logic         rst0;
    logic [127:0] in0;
    logic [3:0]   stb0;
    logic [3:0]   ack0;
    logic [31:0]  out0;
    logic         ostb0;
    logic         oack0;
    logic [1:0]   gid0;
    logic         tstb0;

    // unlocked instance
    logic         rst1;
    logic [127:0] in1;
    logic [3:0]   stb1;
    logic [3:0]   ack1;
    logic [31:0]  out1;
    logic         ostb1;
    logic         oack1;
    logic [1:0]   gid1;
    logic         tstb1;

    int n_chk  = 0;
    int n_pass = 0;

    rs232_tx_arbiter #(
        .N_REQ(4), .WIDTH(32), .EOM(32'h0A), .LOCK(1), .TIMEOUT(16)
    ) u_lock (
        .clk(clk), .rst(rst0), .input_in(in0), .input_in_stb(stb0),
        .input_in_ack(ack0), .output_out(out0), .output_out_stb(ostb0),
        .output_out_ack(oack0), .grant_id(gid0), .timeout_stb(tstb0)
    );

    rs232_tx_arbiter #(
        .N_REQ(4), .WIDTH(32), .EOM(32'h0A), .LOCK(0), .TIMEOUT(16)
    ) u_unlock (
        .clk(clk), .rst(rst1), .input_in(in1), .input_in_stb(stb1),
        .input_in_ack(ack1), .output_out(out1), .output_out_stb(ostb1),
        .output_out_ack(oack1), .grant_id(gid1), .timeout_stb(tstb1)
    );

    typedef struct packed {
        logic         rst;
        logic [3:0]   stb;
        logic         oack;
        logic [127:0] dat;
        logic [3:0]   e_ack;
        logic         e_ostb;
        logic [31:0]  e_out;
        logic [1:0]   e_gid;
        logic         e_tstb;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [127:0] d4(input logic [31:0] r0, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [31:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    // Drive the locked instance before an edge, then settle just after it.
    task automatic step0(input logic r, input logic [3:0] s, input logic oa, input logic [127:0] d);
        @(negedge clk);
        rst0  = r;
        stb0  = s;
        oack0 = oa;
        in0   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string nm, input logic [3:0] e_ack, input logic e_ostb,
                        input logic [31:0] e_out, input logic [1:0] e_gid, input logic e_tstb);
        chk({nm, " ack"},  64'(ack0),  64'(e_ack));
        chk({nm, " ostb"}, 64'(ostb0), 64'(e_ostb));
        chk({nm, " out"},  64'(out0),  64'(e_out));
        chk({nm, " gid"},  64'(gid0),  64'(e_gid));
        chk({nm, " tstb"}, 64'(tstb0), 64'(e_tstb));
    endtask

    initial begin
        logic [127:0] all_eom;
        logic [3:0]   ack_pre;
        int           idx_u0;
        int           idx_u1;
        logic [31:0]  exp_words [4];
        logic [1:0]   exp_gids  [4];
        int           k;

        rst0 = 1'b1; stb0 = '0; oack0 = 1'b0; in0 = '0;
        rst1 = 1'b1; stb1 = '0; oack1 = 1'b1; in1 = '0;
        all_eom = d4(32'h0A, 32'h0A, 32'h0A, 32'h0A);

        // reset with all strobes high, then message lock of requester 1 ("Hi\n")
        vecs[0]  = '{1'b1, 4'hF, 1'b1, d4(32'h0A, 32'h11, 32'h12, 32'h13), 4'h0, 1'b0, 32'h00, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'hF, 1'b1, d4(32'h0A, 32'h11, 32'h12, 32'h13), 4'h0, 1'b0, 32'h00, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'hF, 1'b1, d4(32'h0A, 32'h11, 32'h12, 32'h13), 4'h1, 1'b1, 32'h0A, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 4'hF, 1'b1, d4(32'h0A, 32'h48, 32'h12, 32'h13), 4'h0, 1'b0, 32'h0A, 2'd0, 1'b0};
        vecs[4]  = '{1'b0, 4'hE, 1'b1, d4(32'h00, 32'h48, 32'h12, 32'h13), 4'h2, 1'b1, 32'h48, 2'd1, 1'b0};
        vecs[5]  = '{1'b0, 4'hE, 1'b1, d4(32'h00, 32'h48, 32'h12, 32'h13), 4'h0, 1'b0, 32'h48, 2'd1, 1'b0};
        vecs[6]  = '{1'b0, 4'hE, 1'b1, d4(32'h00, 32'h69, 32'h12, 32'h13), 4'h2, 1'b1, 32'h69, 2'd1, 1'b0};
        vecs[7]  = '{1'b0, 4'hE, 1'b1, d4(32'h00, 32'h69, 32'h12, 32'h13), 4'h0, 1'b0, 32'h69, 2'd1, 1'b0};
        vecs[8]  = '{1'b0, 4'hE, 1'b1, d4(32'h00, 32'h0A, 32'h12, 32'h13), 4'h2, 1'b1, 32'h0A, 2'd1, 1'b0};
        vecs[9]  = '{1'b0, 4'hE, 1'b1, d4(32'h00, 32'h0A, 32'h12, 32'h13), 4'h0, 1'b0, 32'h0A, 2'd1, 1'b0};
        vecs[10] = '{1'b0, 4'hC, 1'b1, d4(32'h00, 32'h00, 32'h12, 32'h13), 4'h4, 1'b1, 32'h12, 2'd2, 1'b0};
        vecs[11] = '{1'b0, 4'hC, 1'b0, d4(32'h00, 32'h00, 32'h12, 32'h13), 4'h0, 1'b1, 32'h12, 2'd2, 1'b0};

        @(posedge clk);
        #1;
        rst1 = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step0(vecs[i].rst, vecs[i].stb, vecs[i].oack, vecs[i].dat);
            chk0($sformatf("vec%0d", i), vecs[i].e_ack, vecs[i].e_ostb,
                 vecs[i].e_out, vecs[i].e_gid, vecs[i].e_tstb);
        end

        // output backpressure: word and strobe frozen, no new acks
        for (int i = 0; i < 50; i++) begin
            step0(1'b0, 4'h8, 1'b0, d4(32'h00, 32'h00, 32'h12, 32'h13));
            chk($sformatf("stall%0d ack", i),  64'(ack0),  64'h0);
            chk($sformatf("stall%0d ostb", i), 64'(ostb0), 64'h1);
            chk($sformatf("stall%0d out", i),  64'(out0),  64'h12);
        end
        step0(1'b0, 4'h8, 1'b1, d4(32'h00, 32'h00, 32'h12, 32'h13));
        chk0("stall_rel", 4'h0, 1'b0, 32'h12, 2'd2, 1'b0);
        step0(1'b0, 4'hC, 1'b1, d4(32'h00, 32'h00, 32'h0A, 32'h13));
        chk0("hold_r2_eom", 4'h4, 1'b1, 32'h0A, 2'd2, 1'b0);
        step0(1'b0, 4'hC, 1'b1, d4(32'h00, 32'h00, 32'h0A, 32'h13));
        chk0("r2_release", 4'h0, 1'b0, 32'h0A, 2'd2, 1'b0);

        // reset mid-stream: back to ptr=0, then fairness with single-word messages
        step0(1'b1, 4'hF, 1'b1, all_eom);
        chk0("rst2", 4'h0, 1'b0, 32'h0, 2'd0, 1'b0);
        for (int g = 0; g < 8; g++) begin
            step0(1'b0, 4'hF, 1'b1, all_eom);
            chk($sformatf("fair%0d gid", g), 64'(gid0), 64'(g % 4));
            chk($sformatf("fair%0d ack", g), 64'(ack0), 64'(4'h1 << (g % 4)));
            chk($sformatf("fair%0d ostb", g), 64'(ostb0), 64'h1);
            step0(1'b0, 4'hF, 1'b1, all_eom);
            chk($sformatf("fair%0d idle", g), 64'({ack0, ostb0}), 64'h0);
        end

        // timeout release: requester 0 sends 'A' and goes quiet, requester 3 waits
        step0(1'b0, 4'h1, 1'b1, d4(32'h41, 32'h00, 32'h00, 32'h13));
        chk0("to_grant", 4'h1, 1'b1, 32'h41, 2'd0, 1'b0);
        step0(1'b0, 4'h1, 1'b1, d4(32'h41, 32'h00, 32'h00, 32'h13));
        chk0("to_xfer", 4'h0, 1'b0, 32'h41, 2'd0, 1'b0);
        for (int e = 1; e <= 16; e++) begin
            step0(1'b0, 4'h8, 1'b1, d4(32'h00, 32'h00, 32'h00, 32'h13));
            chk($sformatf("to_cyc%0d tstb", e), 64'(tstb0), 64'(e == 16));
            chk($sformatf("to_cyc%0d ack", e),  64'(ack0),  64'h0);
        end
        step0(1'b0, 4'h8, 1'b1, d4(32'h00, 32'h00, 32'h00, 32'h13));
        chk0("to_next", 4'h8, 1'b1, 32'h13, 2'd3, 1'b0);

        // stb on the very edge the timer expires: stb wins, no release
        step0(1'b0, 4'h8, 1'b1, d4(32'h00, 32'h00, 32'h00, 32'h13));
        chk0("race_xfer", 4'h0, 1'b0, 32'h13, 2'd3, 1'b0);
        for (int e = 1; e <= 15; e++) begin
            step0(1'b0, 4'h0, 1'b1, d4(32'h00, 32'h00, 32'h00, 32'h00));
            chk($sformatf("race_cyc%0d tstb", e), 64'(tstb0), 64'h0);
        end
        step0(1'b0, 4'h8, 1'b1, d4(32'h00, 32'h00, 32'h00, 32'h0A));
        chk0("race_win", 4'h8, 1'b1, 32'h0A, 2'd3, 1'b0);
        step0(1'b0, 4'h8, 1'b1, d4(32'h00, 32'h00, 32'h00, 32'h0A));
        chk0("race_eom", 4'h0, 1'b0, 32'h0A, 2'd3, 1'b0);
        step0(1'b0, 4'h0, 1'b1, d4(32'h00, 32'h00, 32'h00, 32'h00));
        chk0("race_quiet", 4'h0, 1'b0, 32'h0A, 2'd3, 1'b0);

        // unlocked instance: requesters 0 and 1 stream non-EOM words
        exp_words[0] = 32'h100; exp_gids[0] = 2'd0;
        exp_words[1] = 32'h200; exp_gids[1] = 2'd1;
        exp_words[2] = 32'h101; exp_gids[2] = 2'd0;
        exp_words[3] = 32'h201; exp_gids[3] = 2'd1;
        idx_u0 = 0;
        idx_u1 = 0;
        k = 0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            stb1    = 4'h3;
            in1     = d4(32'h100 + 32'(idx_u0), 32'h200 + 32'(idx_u1), 32'h0, 32'h0);
            ack_pre = ack1;
            @(posedge clk);
            #1;
            if (ack_pre[0]) idx_u0++;
            if (ack_pre[1]) idx_u1++;
            if (s % 2 == 0) begin
                chk($sformatf("unl%0d ostb", k), 64'(ostb1), 64'h1);
                chk($sformatf("unl%0d out", k),  64'(out1),  64'(exp_words[k]));
                chk($sformatf("unl%0d gid", k),  64'(gid1),  64'(exp_gids[k]));
                k++;
            end else begin
                chk($sformatf("unl%0d idle", k), 64'(ostb1), 64'h0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Round-robin, message-locked arbiter that shares the single `output_rs232_tx` stream between several stb/ack producer processes, such as the temperature reporter and debug/status processes. It sits in `user_design` between the producer process instances and the top-level `output_rs232_tx` port. A granted producer keeps the UART until it sends an end-of-message word or goes idle past a timeout, so text lines from different producers never interleave.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: stream data width.
- `EOM`, 32'h0A: end-of-message value, compared against the full word.
- `LOCK`, 1: 1 holds the grant until EOM or timeout; 0 re-arbitrates after every word.
- `TIMEOUT`, 1024: idle cycles in HOLD before forced release, ≥2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `input_in` in N_REQ*WIDTH: requester data, with requester i at bits [i*WIDTH +: WIDTH].
- `input_in_stb` in N_REQ: requester strobes.
- `input_in_ack` out N_REQ: per-requester ack, registered.
- `output_out` out WIDTH: data to the UART transmitter.
- `output_out_stb` out 1: output strobe.
- `output_out_ack` in 1: output ack from the UART.
- `grant_id` out clog2(N_REQ): current or last granted requester.
- `timeout_stb` out 1: one-cycle pulse on a forced release.

## Operation
- A transfer on any stb/ack pair occurs on a rising edge where stb and ack are both high.
- Producers hold stb and data stable until acked.

States: ARB, SEND, HOLD.

ARB:
- Priority is round-robin, starting at `ptr`.
- On an edge with any `input_in_stb` high, the winner `w` is the first requester at or after `ptr` (mod N_REQ) with stb high.
- On that edge: `data_reg`←`input_in[w]`, `grant_id`←w, `input_in_ack[w]`←1, state←SEND.

SEND:
- `output_out_stb`=1 and `output_out`=`data_reg`; all `input_in_ack` are 0.
- On the output transfer, exactly one of the following applies:
  - If LOCK=0 or `data_reg`==EOM: `ptr`←(w+1) mod N_REQ, state←ARB.
  - Otherwise: state←HOLD and the timeout counter is cleared.

HOLD:
- Only requester w is considered; all other stbs are ignored.
- If `input_in_stb[w]` is high: latch the data, pulse `input_in_ack[w]`, state←SEND.
- Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no stb: `timeout_stb` pulses, `ptr`←(w+1) mod N_REQ, state←ARB.

Ack pulse rules:
- `input_in_ack` is high for exactly one cycle per accepted word.
- At most one `input_in_ack` bit is high at any time.

The arbiter has no exception output. `exception` ORing is unchanged in `user_design`.

## Timing
Reset values, taking effect on the edge where `rst`=1:
- State is ARB, `ptr`=0, `grant_id`=0.
- `input_in_ack`=0, `output_out_stb`=0, `output_out`=0, `timeout_stb`=0, counter=0.

Latency and throughput:
- Latency from `input_in_stb` seen in ARB/HOLD to `output_out_stb` is 1 cycle.
- A locked stream with `output_out_ack` tied high sustains 1 word per 2 cycles.

Boundary conditions:
- **Simultaneous requests:** requests in ARB resolve strictly by `ptr` order, so a requester that keeps re-requesting cannot starve the others.
- **Stalled output:** `output_out_ack` held low keeps SEND and its data stable indefinitely. No timeout runs in SEND.
- **Stb in the same cycle as timeout:** if `input_in_stb[w]` rises on the same edge the counter hits TIMEOUT-1, the stb wins and there is no release.
- **Reset mid-operation:** reset in SEND drops the word. The producer was already acked, so the loss is accepted.
- **`ptr` wrap-around:** `ptr` wraps from N_REQ-1 to 0.

## Structure
- Package `rs232_arb_pkg` holds:
  - the state encoding (ARB=0, SEND=1, HOLD=2);
  - the default EOM constant;
  - the clog2 helper function.
- Sub-module `rr_pick`: a combinational round-robin selector taking `req[N_REQ]` and `ptr` and producing `valid` and `winner`.
- `user_design` instantiates the arbiter with each producer's tx stream on one slice.

## Test plan
1. **Reset behaviour:** reset with all stbs high → all outputs 0 during reset. After release, requester 0 is acked first, and `output_out_stb` rises 1 cycle after the ARB edge.
2. **Message lock:** requester 1 sends 'H','i',0x0A while requester 2 strobes continuously. → Output is 48,69,0A with no interleaving, then requester 2 is granted, with `grant_id`=2.
3. **Fairness:** all four requesters send single-word EOM messages continuously → grants go 0,1,2,3,0,…
4. **Timeout release:** requester 0 sends 'A' and then stops, with TIMEOUT=16 → `timeout_stb` pulses exactly 16 cycles after the output transfer, and requester 3 is granted next.
5. **Output backpressure:** `output_out_ack` is held low for 50 cycles → `output_out` and `output_out_stb` stay stable and no further `input_in_ack` is issued.
6. **Unlocked mode:** LOCK=0 with requesters 0 and 1 sending multi-word streams → the output alternates words 0,1,0,1.
